// File: rtl/npu_pkg.sv
// Shared constants, FSM encoding and channel-count decode for the 3x3 conv PE.
package npu_pkg;

  localparam int LANES = 9;
  localparam int DW    = 8;
  localparam int SUM_W = 19;
  localparam int ACC_W = 27;
  localparam int CNT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // A programmed count of 0 encodes the full 256-channel job.
  function automatic logic [CNT_W-1:0] decode_channels(input logic [7:0] cfg);
    return (cfg == 8'd0) ? 9'd256 : {1'b0, cfg};
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// PIPE_LAT-stage valid shift register tracking beats in flight through the multiplier tree.
// any_live covers the input and every stage except the last, i.e. beats still behind the output.
module valid_delay_line #(
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic out_bit,
  output logic any_live
);

  if (PIPE_LAT == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign out_bit        = in_bit;
    assign any_live       = 1'b0;
  end else begin : g_shift
    logic [PIPE_LAT-1:0] stage_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= in_bit;
        for (int i = 1; i < PIPE_LAT; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    always_comb begin
      any_live = in_bit;
      for (int i = 0; i < PIPE_LAT - 1; i++) begin
        any_live = any_live | stage_q[i];
      end
    end

    assign out_bit = stage_q[PIPE_LAT-1];
  end

endmodule

// File: rtl/conv3x3_sequencer.sv
// Feeds per-channel 3x3 windows to the multiplier, accumulates tree sums, returns one result.
// Result valid PIPE_LAT+1 cycles after the last beat; held in OUT until out_ready.
module conv3x3_sequencer
  import npu_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              cfg_channels,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DW-1:0]     in_act,
  input  logic [LANES*DW-1:0]     in_wgt,
  output logic [LANES*DW-1:0]     mul_a,
  output logic [LANES*DW-1:0]     mul_b,
  output logic                    mul_valid,
  input  logic signed [SUM_W-1:0] tree_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LANES*DW-1:0]     mul_a_q, mul_a_d;
  logic [LANES*DW-1:0]     mul_b_q, mul_b_d;
  logic                    mul_valid_q, mul_valid_d;
  logic                    in_hs;
  logic                    pipe_out;
  logic                    pipe_live;

  valid_delay_line #(
    .PIPE_LAT (PIPE_LAT)
  ) u_valid_delay (
    .clk      (clk),
    .reset    (reset),
    .in_bit   (mul_valid_q),
    .out_bit  (pipe_out),
    .any_live (pipe_live)
  );

  assign in_hs = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (in_hs && (remaining_q == CNT_W'(1))) state_d = ST_DRAIN;
      // Leave on the edge that accumulates the final in-flight beat.
      ST_DRAIN: if (pipe_out && !pipe_live) state_d = ST_OUT;
      ST_OUT:   if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    in_ready  = (state_q == ST_RUN) && (remaining_q != '0);
    out_valid = (state_q == ST_OUT);
    out_data  = (state_q == ST_OUT) ? acc_q : '0;
    mul_a     = mul_a_q;
    mul_b     = mul_b_q;
    mul_valid = mul_valid_q;
  end

  always_comb begin
    remaining_d = remaining_q;
    acc_d       = acc_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_valid_d = in_hs;
    if ((state_q == ST_IDLE) && start) begin
      remaining_d = decode_channels(cfg_channels);
      acc_d       = '0;
    end
    if (in_hs) begin
      remaining_d = remaining_q - CNT_W'(1);
      mul_a_d     = in_act;
      mul_b_d     = in_wgt;
    end
    if (pipe_out) begin
      acc_d = acc_q + ACC_W'(tree_sum);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining_q <= '0;
      acc_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_valid_q <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_valid_q <= mul_valid_d;
    end
  end

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Drives a PIPE_LAT=2 and a PIPE_LAT=0 sequencer against a behavioural multiplier/tree and a dot-product model.
module tb_conv3x3_sequencer;
  import npu_pkg::*;

  localparam int PW = LANES * DW;
  localparam int LAT [2] = '{2, 0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                    start_s     [2];
  logic [7:0]              cfg_s       [2];
  logic                    busy_s      [2];
  logic                    in_valid_s  [2];
  logic                    in_ready_s  [2];
  logic [PW-1:0]           in_act_s    [2];
  logic [PW-1:0]           in_wgt_s    [2];
  logic [PW-1:0]           mul_a_s     [2];
  logic [PW-1:0]           mul_b_s     [2];
  logic                    mul_valid_s [2];
  logic signed [SUM_W-1:0] tree_s      [2];
  logic                    out_valid_s [2];
  logic                    out_ready_s [2];
  logic signed [ACC_W-1:0] out_data_s  [2];

  logic [PW-1:0] ba [256];
  logic [PW-1:0] bw [256];

  int n_chk    = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  conv3x3_sequencer #(.PIPE_LAT(2)) u_dut_lat2 (
    .clk(clk), .reset(rst_n), .start(start_s[0]), .cfg_channels(cfg_s[0]), .busy(busy_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_act(in_act_s[0]), .in_wgt(in_wgt_s[0]),
    .mul_a(mul_a_s[0]), .mul_b(mul_b_s[0]), .mul_valid(mul_valid_s[0]), .tree_sum(tree_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_data(out_data_s[0])
  );

  conv3x3_sequencer #(.PIPE_LAT(0)) u_dut_lat0 (
    .clk(clk), .reset(rst_n), .start(start_s[1]), .cfg_channels(cfg_s[1]), .busy(busy_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_act(in_act_s[1]), .in_wgt(in_wgt_s[1]),
    .mul_a(mul_a_s[1]), .mul_b(mul_b_s[1]), .mul_valid(mul_valid_s[1]), .tree_sum(tree_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_data(out_data_s[1])
  );

  function automatic longint dot(input logic [PW-1:0] a, input logic [PW-1:0] b);
    longint s = 0;
    for (int k = 0; k < LANES; k++) begin
      s += longint'($signed(a[k*DW +: DW])) * longint'($signed(b[k*DW +: DW]));
    end
    return s;
  endfunction

  // Multiplier + adder tree: two register stages for the first DUT, purely combinational for the second.
  logic signed [SUM_W-1:0] tree_d0, tree_d1;
  always @(posedge clk) begin
    tree_d0 <= SUM_W'(dot(mul_a_s[0], mul_b_s[0]));
    tree_d1 <= tree_d0;
  end
  assign tree_s[0] = tree_d1;
  assign tree_s[1] = SUM_W'(dot(mul_a_s[1], mul_b_s[1]));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input int sel, input string tag);
    chk({tag, "_busy"},      longint'(busy_s[sel]), 0);
    chk({tag, "_in_ready"},  longint'(in_ready_s[sel]), 0);
    chk({tag, "_mul_valid"}, longint'(mul_valid_s[sel]), 0);
    chk({tag, "_mul_a_nz"},  longint'(mul_a_s[sel] != '0), 0);
    chk({tag, "_mul_b_nz"},  longint'(mul_b_s[sel] != '0), 0);
    chk({tag, "_out_valid"}, longint'(out_valid_s[sel]), 0);
    chk({tag, "_out_data"},  longint'(out_data_s[sel]), 0);
  endtask

  function automatic logic [PW-1:0] all_lanes(input logic [7:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [PW-1:0] lane0(input logic [7:0] v);
    return {{(PW-DW){1'b0}}, v};
  endfunction

  // One complete job: start, feed nch beats from ba/bw, drain, hold result, output handshake.
  task automatic run_job(input int sel, input int nch, input int gap_pct, input int hold,
                         input bit use_fixed, input longint fixed_exp);
    longint exp_sum = 0;
    int     sent    = 0;
    int     cyc     = 0;
    int     last_hs = 0;
    bit     hs;
    @(negedge clk);
    start_s[sel] = 1'b1;
    cfg_s[sel]   = 8'(nch);
    @(negedge clk);
    start_s[sel] = 1'b0;
    chk("busy_after_start", longint'(busy_s[sel]), 1);
    while (sent < nch && cyc < 4000) begin
      in_valid_s[sel] = ($urandom_range(99) >= gap_pct);
      in_act_s[sel]   = ba[sent];
      in_wgt_s[sel]   = bw[sent];
      chk("in_ready_run", longint'(in_ready_s[sel]), 1);
      hs = in_valid_s[sel] && in_ready_s[sel];
      if (hs) begin
        exp_sum += dot(ba[sent], bw[sent]);
        sent++;
        last_hs = edge_cnt + 1;
      end
      cyc++;
      @(negedge clk);
    end
    if (sent < nch) chk("beats_timeout", sent, nch);
    in_valid_s[sel] = 1'b1;
    in_act_s[sel]   = all_lanes(8'h7f);
    in_wgt_s[sel]   = all_lanes(8'h7f);
    cyc = 0;
    while (!out_valid_s[sel] && cyc < 50) begin
      chk("in_ready_drain", longint'(in_ready_s[sel]), 0);
      chk("busy_drain", longint'(busy_s[sel]), 1);
      @(negedge clk);
      cyc++;
    end
    chk("out_valid_rise", longint'(out_valid_s[sel]), 1);
    chk("out_latency", longint'(edge_cnt - last_hs), longint'(LAT[sel] + 1));
    chk("out_data_model", longint'(out_data_s[sel]), exp_sum);
    if (use_fixed) chk("out_data_fixed", longint'(out_data_s[sel]), fixed_exp);
    for (int i = 0; i < hold; i++) begin
      start_s[sel]     = 1'b1;
      out_ready_s[sel] = 1'b0;
      @(negedge clk);
      chk("hold_valid", longint'(out_valid_s[sel]), 1);
      chk("hold_data", longint'(out_data_s[sel]), exp_sum);
      chk("hold_in_ready", longint'(in_ready_s[sel]), 0);
      chk("hold_busy", longint'(busy_s[sel]), 1);
      start_s[sel] = 1'b0;
    end
    out_ready_s[sel] = 1'b1;
    start_s[sel]     = 1'b1;
    @(negedge clk);
    out_ready_s[sel] = 1'b0;
    start_s[sel]     = 1'b0;
    in_valid_s[sel]  = 1'b0;
    chk("idle_busy", longint'(busy_s[sel]), 0);
    chk("idle_out_valid", longint'(out_valid_s[sel]), 0);
    @(negedge clk);
    chk("no_restart_busy", longint'(busy_s[sel]), 0);
    chk("no_restart_in_ready", longint'(in_ready_s[sel]), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start_s[s] = 1'b0; cfg_s[s] = '0; in_valid_s[s] = 1'b0;
      in_act_s[s] = '0; in_wgt_s[s] = '0; out_ready_s[s] = 1'b0;
    end
    #1;
    chk_zero_outputs(0, "reset_lat2");
    chk_zero_outputs(1, "reset_lat0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single channel, 9 * 2 * 3
    ba[0] = all_lanes(8'd2); bw[0] = all_lanes(8'd3);
    run_job(0, 1, 0, 0, 1'b1, 54);

    // Alternating extreme products
    for (int i = 0; i < 4; i++) begin
      ba[i] = all_lanes(8'h80);
      bw[i] = (i % 2 == 0) ? all_lanes(8'h80) : all_lanes(8'h7f);
    end
    run_job(0, 4, 0, 0, 1'b1, 2304);

    // 256 channels at the maximum product with random gaps
    for (int i = 0; i < 256; i++) begin
      ba[i] = all_lanes(8'h80); bw[i] = all_lanes(8'h80);
    end
    run_job(0, 256, 30, 0, 1'b1, 37748736);

    // Result held under backpressure while start/in_valid pulse
    ba[0] = all_lanes(8'hfd); bw[0] = all_lanes(8'd7);
    ba[1] = all_lanes(8'd5);  bw[1] = all_lanes(8'hfe);
    run_job(0, 2, 0, 5, 1'b1, -279);

    // Asynchronous reset after 2 of 4 beats
    @(negedge clk);
    start_s[0] = 1'b1; cfg_s[0] = 8'd4;
    @(negedge clk);
    start_s[0] = 1'b0;
    in_valid_s[0] = 1'b1; in_act_s[0] = all_lanes(8'd9); in_wgt_s[0] = all_lanes(8'd9);
    repeat (2) @(negedge clk);
    in_valid_s[0] = 1'b0;
    chk("pre_reset_busy", longint'(busy_s[0]), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs(0, "midjob_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ba[0] = all_lanes(8'd2); bw[0] = all_lanes(8'd3);
    run_job(0, 1, 0, 1, 1'b1, 54);

    // Combinational tree: sums 10, -20, 5 back-to-back
    ba[0] = lane0(8'd10); ba[1] = lane0(8'hec); ba[2] = lane0(8'd5);
    for (int i = 0; i < 3; i++) bw[i] = lane0(8'd1);
    run_job(1, 3, 0, 0, 1'b1, -5);

    // Random jobs on both pipeline depths
    for (int j = 0; j < 8; j++) begin
      int nch;
      nch = $urandom_range(1, 12);
      for (int i = 0; i < nch; i++) begin
        ba[i] = PW'({$urandom(), $urandom(), $urandom()});
        bw[i] = PW'({$urandom(), $urandom(), $urandom()});
      end
      run_job(j % 2, nch, $urandom_range(0, 50), $urandom_range(0, 3), 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
